// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock ratio monitor: FSM state encoding
// and the per-phase tolerance window.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } tol_bounds_t;

  // Inclusive window around n/2; the low bound clamps at zero for wide tolerances.
  function automatic tol_bounds_t tol_bounds(input int n, input int tol);
    tol_bounds_t b;
    b.lo = (tol >= n / 2) ? 32'd0 : 32'(n / 2 - tol);
    b.hi = 32'(n / 2 + tol);
    return b;
  endfunction

  function automatic logic in_bounds(input logic [31:0] v, input tol_bounds_t b);
    return (v >= b.lo) && (v <= b.hi);
  endfunction

endpackage

// File: rtl/clock_ratio_monitor_if.sv
// Control and status bundle between the monitor and whoever drives/observes it.
interface clock_ratio_monitor_if #(
  parameter int CW = 16
);
  logic          en;
  logic          sig_in;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] low_cnt;
  logic          meas_valid;
  logic          locked;
  logic          err_ratio;
  logic          err_stuck;

  modport master (
    output en, sig_in,
    input  high_cnt, low_cnt, meas_valid, locked, err_ratio, err_stuck
  );

  modport slave (
    input  en, sig_in,
    output high_cnt, low_cnt, meas_valid, locked, err_ratio, err_stuck
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a one-flop edge detector; pulses are
// combinational off the flops so the consumer registers them on the third edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise_p,
  output logic fall_p
);
  // sh[1:0] synchronize, sh[2] holds the previous synchronized level
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], sig_in};
  end

  assign rise_p = sh[1] & ~sh[2];
  assign fall_p = ~sh[1] & sh[2];
endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures high/low phase lengths of a divided clock, tracks lock against the
// expected ratio N, and flags out-of-tolerance periods and stuck inputs.
module clock_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int N        = 4,
  parameter int CW       = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0,
  parameter int TIMEOUT  = 4 * N
) (
  input logic                  clk,
  input logic                  rst,
  clock_ratio_monitor_if.slave bus
);

  if (N < 2 || (N % 2) != 0) begin : g_chk_n
    $error("clock_ratio_monitor: N must be even and at least 2");
  end
  if (CW > 32 || TIMEOUT < 1 || ((64'd1 << CW) - 64'd1) <= 64'(TIMEOUT)) begin : g_chk_cw
    $error("clock_ratio_monitor: CW too narrow for TIMEOUT (or TIMEOUT < 1)");
  end
  if (LOCK_CNT < 1 || TOL < 0) begin : g_chk_misc
    $error("clock_ratio_monitor: LOCK_CNT must be >= 1 and TOL >= 0");
  end

  localparam int               GW     = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]    CMAX   = '1;
  localparam logic [CW-1:0]    TMO_M1 = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0]    LOCK_M1 = GW'(LOCK_CNT - 1);
  localparam tol_bounds_t      BND    = tol_bounds(N, TOL);

  state_t        state;
  logic [CW-1:0] cnt, cnt_inc, hi_lat, hcnt, lcnt;
  logic [GW-1:0] good;
  logic          hv, mv, lk, er, es;
  logic          rise_p, fall_p, edge_p, tmo, good_per;

  sync_edge_detect u_sed (
    .clk   (clk),
    .rst   (rst),
    .sig_in(bus.sig_in),
    .rise_p(rise_p),
    .fall_p(fall_p)
  );

  // Phase length is counter+1 because the counter restarts at 0 on the edge cycle.
  assign cnt_inc  = (cnt == CMAX) ? cnt : cnt + 1'b1;
  assign edge_p   = rise_p | fall_p;
  // An edge landing on the timeout cycle wins; this also keeps err_stuck and err_ratio exclusive.
  assign tmo      = (cnt == TMO_M1) && !edge_p && (state != S_IDLE);
  assign good_per = in_bounds(32'(hi_lat), BND) && in_bounds(32'(cnt_inc), BND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_lat <= '0;
      hcnt   <= '0;
      lcnt   <= '0;
      good   <= '0;
      hv     <= 1'b0;
      mv     <= 1'b0;
      lk     <= 1'b0;
      er     <= 1'b0;
      es     <= 1'b0;
    end else begin
      mv <= 1'b0;
      er <= 1'b0;
      es <= 1'b0;
      if (!bus.en) begin
        state  <= S_IDLE;
        lk     <= 1'b0;
        cnt    <= '0;
        hi_lat <= '0;
        good   <= '0;
        hv     <= 1'b0;
      end else begin
        cnt <= edge_p ? '0 : cnt_inc;
        unique case (state)
          S_IDLE: begin
            state <= S_SYNC;
            cnt   <= '0;
          end
          S_SYNC: begin
            if (rise_p) begin
              state <= S_ACQUIRE;
              good  <= '0;
              hv    <= 1'b0;
            end
          end
          S_ACQUIRE, S_LOCKED: begin
            if (fall_p) begin
              hi_lat <= cnt_inc;
              hv     <= 1'b1;
            end
            if (rise_p && hv) begin
              hcnt <= hi_lat;
              lcnt <= cnt_inc;
              mv   <= 1'b1;
              hv   <= 1'b0;
              if (good_per) begin
                if (state == S_ACQUIRE) begin
                  good <= good + 1'b1;
                  if (good == LOCK_M1) begin
                    state <= S_LOCKED;
                    lk    <= 1'b1;
                  end
                end
              end else begin
                er    <= 1'b1;
                good  <= '0;
                state <= S_ACQUIRE;
                lk    <= 1'b0;
              end
            end
          end
        endcase
        if (tmo) begin
          es    <= 1'b1;
          state <= S_SYNC;
          lk    <= 1'b0;
          cnt   <= '0;
          good  <= '0;
          hv    <= 1'b0;
        end
      end
    end
  end

  assign bus.high_cnt   = hcnt;
  assign bus.low_cnt    = lcnt;
  assign bus.meas_valid = mv;
  assign bus.locked     = lk;
  assign bus.err_ratio  = er;
  assign bus.err_stuck  = es;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Self-checking bench: drives sig_in as a list of phase lengths and compares the
// measurement stream against a period-level lock/tolerance model.
module tb_clock_ratio_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_ratio_monitor_if #(.CW(16)) b4 ();
  clock_ratio_monitor_if #(.CW(16)) b8 ();

  clock_ratio_monitor dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  clock_ratio_monitor #(.N(8), .TOL(1)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  typedef struct { int h; int l; bit er; bit lk; } meas_t;
  meas_t m4_q[$], m8_q[$];
  int stuck4 = 0, stuck8 = 0, orph = 0, both = 0;
  int checks = 0, failures = 0;

  always @(negedge clk) begin
    if (b4.meas_valid) m4_q.push_back('{int'(b4.high_cnt), int'(b4.low_cnt), b4.err_ratio, b4.locked});
    if (b8.meas_valid) m8_q.push_back('{int'(b8.high_cnt), int'(b8.low_cnt), b8.err_ratio, b8.locked});
    if (b4.err_stuck) stuck4++;
    if (b8.err_stuck) stuck8++;
    if ((b4.err_ratio && !b4.meas_valid) || (b8.err_ratio && !b8.meas_valid)) orph++;
    if ((b4.err_ratio && b4.err_stuck) || (b8.err_ratio && b8.err_stuck)) both++;
  end

  task automatic set_sig(input int sel, input logic v);
    if (sel == 0) b4.sig_in = v; else b8.sig_in = v;
  endtask
  task automatic set_en(input int sel, input logic v);
    if (sel == 0) b4.en = v; else b8.en = v;
  endtask
  task automatic drive(input int sel, input logic v, input int len);
    set_sig(sel, v);
    repeat (len) @(negedge clk);
  endtask
  function automatic int qsize(input int sel);
    if (sel == 0) return m4_q.size();
    return m8_q.size();
  endfunction
  function automatic meas_t qget(input int sel, input int i);
    if (sel == 0) return m4_q[i];
    return m8_q[i];
  endfunction
  function automatic int nstuck(input int sel);
    if (sel == 0) return stuck4;
    return stuck8;
  endfunction
  function automatic logic get_locked(input int sel);
    if (sel == 0) return b4.locked;
    return b8.locked;
  endfunction
  function automatic int get_h(input int sel);
    if (sel == 0) return int'(b4.high_cnt);
    return int'(b8.high_cnt);
  endfunction
  function automatic int get_l(input int sel);
    if (sel == 0) return int'(b4.low_cnt);
    return int'(b8.low_cnt);
  endfunction

  // One enabled session: idle-low lead-in, the given full periods, then a closing rise.
  task automatic run_session(input int sel, input int hs[$], input int ls[$], input string name,
                             output int last_h, output int last_l);
    int base, st0, or0, bo0, lo, hi, good, n, tol;
    bit lk;
    meas_t e[$];
    meas_t o;
    n = (sel == 0) ? 4 : 8;
    tol = (sel == 0) ? 0 : 1;
    base = qsize(sel); st0 = nstuck(sel); or0 = orph; bo0 = both;
    set_en(sel, 1'b1);
    drive(sel, 1'b0, 4);
    foreach (hs[i]) begin
      drive(sel, 1'b1, hs[i]);
      drive(sel, 1'b0, ls[i]);
    end
    drive(sel, 1'b1, 5);
    lo = n / 2 - tol; hi = n / 2 + tol; good = 0; lk = 1'b0;
    foreach (hs[i]) begin
      bit ok;
      ok = (hs[i] >= lo) && (hs[i] <= hi) && (ls[i] >= lo) && (ls[i] <= hi);
      if (!ok) begin good = 0; lk = 1'b0; end
      else if (!lk) begin good++; lk = (good >= 4); end
      e.push_back('{hs[i], ls[i], !ok, lk});
    end
    checks++;
    if (qsize(sel) - base !== e.size()) begin
      failures++;
      $display("FAIL %s meas_count got=%0d exp=%0d", name, qsize(sel) - base, e.size());
    end else begin
      foreach (e[i]) begin
        o = qget(sel, base + i);
        checks++;
        if (o.h !== e[i].h || o.l !== e[i].l || o.er !== e[i].er || o.lk !== e[i].lk) begin
          failures++;
          $display("FAIL %s meas[%0d] got=%0d/%0d er=%0b lk=%0b exp=%0d/%0d er=%0b lk=%0b",
                   name, i, o.h, o.l, o.er, o.lk, e[i].h, e[i].l, e[i].er, e[i].lk);
        end
      end
    end
    checks++;
    if (get_locked(sel) !== lk) begin
      failures++;
      $display("FAIL %s final_locked got=%0b exp=%0b", name, get_locked(sel), lk);
    end
    checks++;
    if (nstuck(sel) - st0 !== 0 || orph - or0 !== 0 || both - bo0 !== 0) begin
      failures++;
      $display("FAIL %s spurious_err stuck=%0d orphan_ratio=%0d both=%0d exp=0/0/0",
               name, nstuck(sel) - st0, orph - or0, both - bo0);
    end
    last_h = (e.size() > 0) ? e[e.size()-1].h : get_h(sel);
    last_l = (e.size() > 0) ? e[e.size()-1].l : get_l(sel);
  endtask

  task automatic end_en(input int sel, input int gap, input int h, input int l, input string name);
    set_en(sel, 1'b0);
    @(negedge clk);
    checks++;
    if (get_locked(sel) !== 1'b0) begin
      failures++;
      $display("FAIL %s en_off_locked got=%0b exp=0", name, get_locked(sel));
    end
    checks++;
    if (get_h(sel) !== h || get_l(sel) !== l) begin
      failures++;
      $display("FAIL %s en_off_hold got=%0d/%0d exp=%0d/%0d", name, get_h(sel), get_l(sel), h, l);
    end
    repeat (gap - 1) @(negedge clk);
  endtask

  function automatic int all_out(input int sel);
    if (sel == 0)
      return int'(b4.high_cnt) + int'(b4.low_cnt) + int'(b4.meas_valid) + int'(b4.locked)
             + int'(b4.err_ratio) + int'(b4.err_stuck);
    return int'(b8.high_cnt) + int'(b8.low_cnt) + int'(b8.meas_valid) + int'(b8.locked)
           + int'(b8.err_ratio) + int'(b8.err_stuck);
  endfunction

  task automatic test_reset();
    #12;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (all_out(s) !== 0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got_sum=%0d exp=0", s, all_out(s));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lock();
    int h, l;
    run_session(0, '{2,2,2,2,2,2}, '{2,2,2,2,2,2}, "lock_n4", h, l);
    end_en(0, 4, h, l, "lock_n4");
  endtask

  task automatic test_stretch();
    int h, l;
    run_session(0, '{2,2,2,2,2,5,2,2,2,2,2}, '{2,2,2,2,2,2,2,2,2,2,2}, "stretch", h, l);
    end_en(0, 4, h, l, "stretch");
  endtask

  task automatic test_tol_n8();
    int h, l;
    run_session(1, '{3,3,3,3,3,2,4}, '{5,5,5,5,5,6,4}, "tol_n8", h, l);
    end_en(1, 4, h, l, "tol_n8");
  endtask

  task automatic test_timeout_edge();
    int h, l;
    run_session(0, '{2,2,2,2,2,2}, '{2,2,2,2,16,2}, "tmo_edge", h, l);
    end_en(0, 4, h, l, "tmo_edge");
  endtask

  task automatic test_stuck();
    int h, l, first, n_es, base;
    logic lk_at;
    run_session(0, '{2,2,2,2,2,2}, '{2,2,2,2,2,2}, "stuck_pre", h, l);
    first = -1; n_es = 0; lk_at = 1'b1; base = qsize(0);
    set_sig(0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (b4.err_stuck) begin
        n_es++;
        if (first < 0) begin first = k; lk_at = b4.locked; end
      end
    end
    // 3 clk for the edge to register, then TIMEOUT=16 without an edge
    checks++;
    if (first !== 19) begin failures++; $display("FAIL stuck_time got=%0d exp=19", first); end
    checks++;
    if (n_es !== 1) begin failures++; $display("FAIL stuck_pulses got=%0d exp=1", n_es); end
    checks++;
    if (lk_at !== 1'b0) begin failures++; $display("FAIL stuck_locked got=%0b exp=0", lk_at); end
    checks++;
    if (qsize(0) !== base) begin failures++; $display("FAIL stuck_meas got=%0d exp=0", qsize(0) - base); end
    run_session(0, '{2,2,2,2,2}, '{2,2,2,2,2}, "stuck_relock", h, l);
    end_en(0, 4, h, l, "stuck_relock");
  endtask

  task automatic test_reset_mid();
    int h, l;
    set_en(0, 1'b1);
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 2); drive(0, 1'b0, 2);
    drive(0, 1'b1, 2); drive(0, 1'b0, 2);
    drive(0, 1'b1, 5);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_out(0) !== 0) begin
      failures++;
      $display("FAIL reset_mid_outputs got_sum=%0d exp=0", all_out(0));
    end
    set_sig(0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_session(0, '{2,2,2,2,2}, '{2,2,2,2,2}, "reset_mid", h, l);
    end_en(0, 4, h, l, "reset_mid");
  endtask

  task automatic test_en_drop();
    int h, l;
    run_session(0, '{2,2,2,2,2,2}, '{2,2,2,2,2,2}, "en_drop_pre", h, l);
    end_en(0, 1, h, l, "en_drop");
    run_session(0, '{2,2,2,2}, '{2,2,2,2}, "en_drop_relock", h, l);
    end_en(0, 4, h, l, "en_drop_relock");
  endtask

  task automatic test_random();
    int hs[$], ls[$];
    int h, l;
    for (int i = 0; i < 30; i++) begin
      hs.push_back(($urandom_range(0, 9) < 7) ? 2 : int'($urandom_range(1, 6)));
      ls.push_back(($urandom_range(0, 9) < 7) ? 2 : int'($urandom_range(1, 6)));
    end
    run_session(0, hs, ls, "rand_n4", h, l);
    end_en(0, 4, h, l, "rand_n4");
    hs.delete(); ls.delete();
    for (int i = 0; i < 30; i++) begin
      hs.push_back(($urandom_range(0, 9) < 7) ? int'($urandom_range(3, 5)) : int'($urandom_range(2, 7)));
      ls.push_back(($urandom_range(0, 9) < 7) ? int'($urandom_range(3, 5)) : int'($urandom_range(2, 7)));
    end
    run_session(1, hs, ls, "rand_n8", h, l);
    end_en(1, 4, h, l, "rand_n8");
  endtask

  initial begin
    b4.en = 1'b0; b4.sig_in = 1'b0;
    b8.en = 1'b0; b8.sig_in = 1'b0;
    test_reset();
    test_lock();
    test_stretch();
    test_tol_n8();
    test_timeout_edge();
    test_stuck();
    test_reset_mid();
    test_en_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_ratio_monitor.md
CLOCK_RATIO_MONITOR -- requirements
Module: clock_ratio_monitor

Interface
REQ-001 Parameter N, default 4: expected division ratio of the monitored clock; even, at least 2.
REQ-002 Parameter CW, default 16: width of the measurement counters; 2^CW-1 SHALL exceed TIMEOUT.
REQ-003 Parameter LOCK_CNT, default 4: consecutive in-tolerance periods required to assert lock.
REQ-004 Parameter TOL, default 0: allowed deviation, in clk cycles, of each phase from N/2.
REQ-005 Parameter TIMEOUT, default 4*N: clk cycles without a detected edge before a stuck fault.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  monitor enable; low forces IDLE.
REQ-009 sig_in  input  1  divided clock under test; treated as asynchronous.
REQ-010 high_cnt  output  CW  last measured high-phase length, in clk cycles.
REQ-011 low_cnt  output  CW  last measured low-phase length, in clk cycles.
REQ-012 meas_valid  output  1  one-cycle pulse when high_cnt and low_cnt update together.
REQ-013 locked  output  1  high while in LOCKED.
REQ-014 err_ratio  output  1  one-cycle pulse when a completed period is out of tolerance.
REQ-015 err_stuck  output  1  one-cycle pulse on timeout.

Function
REQ-016 sig_in SHALL pass through a 2-flop synchronizer, then a 1-flop edge detector; an edge is registered 3 clk cycles after the sig_in transition.
REQ-017 A phase counter SHALL clear on every detected edge and otherwise increment, saturating at 2^CW-1.
REQ-018 On each falling edge, the completed high-phase length SHALL be latched internally (value = counter + 1).
REQ-019 On each rising edge following a latched high phase, high_cnt and low_cnt SHALL update and meas_valid SHALL pulse in the same cycle.
REQ-020 A period is good when both phases lie within N/2-TOL to N/2+TOL inclusive; otherwise it is bad.
REQ-021 FSM states: IDLE, SYNC, ACQUIRE, LOCKED.
REQ-022 IDLE: when en=1, go to SYNC.
REQ-023 SYNC: discard the partial period; on the first rising edge, go to ACQUIRE with the good count cleared.
REQ-024 ACQUIRE: a good period increments the good count; the count reaching LOCK_CNT moves to LOCKED.
REQ-025 ACQUIRE: a bad period pulses err_ratio and clears the good count.
REQ-026 LOCKED: a bad period pulses err_ratio, clears the good count and returns to ACQUIRE; locked falls in the same cycle.
REQ-027 Any state except IDLE: the phase counter reaching TIMEOUT pulses err_stuck once and returns to SYNC.
REQ-028 en=0 in any state: go to IDLE next cycle; locked=0; counters clear; high_cnt and low_cnt hold.
REQ-029 A timeout coinciding with a detected edge SHALL resolve in favour of the edge (no err_stuck).
REQ-030 err_ratio and err_stuck SHALL never both pulse in the same cycle.

Reset
REQ-031 rst high SHALL asynchronously clear all of the following: synchronizer flops, edge-detect flop, all counters, high_cnt, low_cnt, meas_valid, locked, err_ratio, err_stuck; the FSM SHALL go to IDLE.
REQ-032 Deassertion of rst SHALL be handled synchronously by the surrounding reset logic; after deassertion, lock SHALL be reacquired from SYNC.

Structure
REQ-033 Package clk_mon_pkg SHALL hold the FSM state enum typedef and a function computing the tolerance bounds.
REQ-034 Sub-module sync_edge_detect SHALL contain the synchronizer and edge detector, with outputs rise_p and fall_p.
REQ-035 All parameter legality (even N, CW sufficiency) SHALL be checked at elaboration.

Verification
REQ-036 N=4, sig_in from a divide-by-4 driven by clk, en=1 -> high_cnt=2, low_cnt=2 at every meas_valid; locked after 4 good periods.
REQ-037 Locked at N=4, then one high phase stretched to 5 cycles -> err_ratio pulses once, locked drops, relock after 4 good periods.
REQ-038 N=8, TOL=1, phases of 3/5 -> no error, locked; phases of 2/6 -> err_ratio.
REQ-039 Locked, then sig_in held low -> err_stuck exactly 16 cycles (N=4) after the last edge; state SYNC; locked=0.
REQ-040 rst asserted mid-ACQUIRE between clk edges -> all outputs 0 immediately; after release with en=1, no meas_valid before the first full period.
REQ-041 en dropped for 1 cycle while locked -> locked=0, high_cnt and low_cnt held, relock requires SYNC plus 4 periods.
